// File: rtl/bpm_test_link_rx.sv
// Receive-side parser for the BPM test link: checks header/payload framing on the
// Aurora RX stream, strobes out good packets and keeps per-FA-cycle bitmap and counters.
module bpm_test_link_rx #(
  parameter int                     MAGIC_WIDTH     = 16,
  parameter int                     MAGIC_START_BIT = 16,
  parameter int                     INDEX_WIDTH     = 5,
  parameter int                     INDEX_START_BIT = 10,
  parameter int                     NUM_DATA_WORDS  = 3,
  parameter logic [MAGIC_WIDTH-1:0] HEADER_MAGIC    = 16'hA5BE,
  parameter int                     COUNT_WIDTH     = 16
) (
  input  logic                         auroraUserClk,
  input  logic                         auroraResetN,
  input  logic                         auroraFAstrobe,
  input  logic [31:0]                  AXI_STREAM_RX_tdata,
  input  logic                         AXI_STREAM_RX_tvalid,
  input  logic                         AXI_STREAM_RX_tlast,
  output logic                         packetStrobe,
  output logic [INDEX_WIDTH-1:0]       packetIndex,
  output logic [32*NUM_DATA_WORDS-1:0] packetData,
  output logic                         statusStrobe,
  output logic [1:0]                   statusCode,
  output logic [2**INDEX_WIDTH-1:0]    cycleBitmap,
  output logic [COUNT_WIDTH-1:0]       goodCount,
  output logic [COUNT_WIDTH-1:0]       errorCount,
  output logic [1:0]                   fsm_state_o
);

  localparam int CW = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
  localparam int DW = 32 * NUM_DATA_WORDS;
  localparam int BW = 2 ** INDEX_WIDTH;
  localparam logic [CW-1:0] LAST_WORD = CW'(NUM_DATA_WORDS - 1);
  localparam logic [CW-1:0] WCNT_ONE  = CW'(1);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_MAGIC = 2'd1;
  localparam logic [1:0] ST_SHORT = 2'd2;
  localparam logic [1:0] ST_LONG  = 2'd3;

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]          wcnt_q, wcnt_d;
  logic [DW-1:0]          data_q, data_d;
  logic [1:0]             pend_q, pend_d;
  logic [BW-1:0]          work_q;

  logic                   done, good, magic_ok;
  logic [1:0]             code;
  logic [BW-1:0]          set_mask;

  assign magic_ok    = AXI_STREAM_RX_tdata[MAGIC_START_BIT +: MAGIC_WIDTH] == HEADER_MAGIC;
  assign fsm_state_o = state_q;

  // Stream handshake: a beat is any cycle with tvalid=1; there is no tready, every beat is consumed.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    data_d   = data_q;
    pend_d   = pend_q;
    done     = 1'b0;
    good     = 1'b0;
    code     = ST_OK;
    set_mask = '0;
    if (AXI_STREAM_RX_tvalid) begin
      case (state_q)
        S_HEADER: begin
          if (AXI_STREAM_RX_tlast) begin
            done = 1'b1;
            code = magic_ok ? ST_SHORT : ST_MAGIC;
          end else if (magic_ok) begin
            idx_d   = AXI_STREAM_RX_tdata[INDEX_START_BIT +: INDEX_WIDTH];
            wcnt_d  = '0;
            state_d = S_DATA;
          end else begin
            pend_d  = ST_MAGIC;
            state_d = S_DROP;
          end
        end
        S_DATA: begin
          for (int w = 0; w < NUM_DATA_WORDS; w++) begin
            if (wcnt_q == CW'(w)) data_d[w*32 +: 32] = AXI_STREAM_RX_tdata;
          end
          wcnt_d = wcnt_q + WCNT_ONE;
          if (wcnt_q == LAST_WORD) begin
            if (AXI_STREAM_RX_tlast) begin
              done    = 1'b1;
              good    = 1'b1;
              state_d = S_HEADER;
            end else begin
              pend_d  = ST_LONG;
              state_d = S_DROP;
            end
          end else if (AXI_STREAM_RX_tlast) begin
            done    = 1'b1;
            code    = ST_SHORT;
            state_d = S_HEADER;
          end
        end
        S_DROP: begin
          if (AXI_STREAM_RX_tlast) begin
            done    = 1'b1;
            code    = pend_q;
            state_d = S_HEADER;
          end
        end
        default: state_d = S_HEADER;
      endcase
    end
    if (good) set_mask[idx_q] = 1'b1;
  end

  always_ff @(posedge auroraUserClk) begin
    if (!auroraResetN) begin
      state_q      <= S_HEADER;
      idx_q        <= '0;
      wcnt_q       <= '0;
      data_q       <= '0;
      pend_q       <= ST_OK;
      work_q       <= '0;
      packetStrobe <= 1'b0;
      packetIndex  <= '0;
      packetData   <= '0;
      statusStrobe <= 1'b0;
      statusCode   <= ST_OK;
      cycleBitmap  <= '0;
      goodCount    <= '0;
      errorCount   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      data_q       <= data_d;
      pend_q       <= pend_d;
      packetStrobe <= good;
      statusStrobe <= done;
      if (done) statusCode <= code;
      if (good) begin
        packetIndex <= idx_q;
        packetData  <= data_d;
        if (goodCount != {COUNT_WIDTH{1'b1}}) goodCount <= goodCount + 1'b1;
      end
      if (done && !good && (errorCount != {COUNT_WIDTH{1'b1}})) errorCount <= errorCount + 1'b1;
      // A completion on the strobe edge belongs to the closing FA cycle.
      if (auroraFAstrobe) begin
        cycleBitmap <= work_q | set_mask;
        work_q      <= '0;
      end else begin
        work_q <= work_q | set_mask;
      end
    end
  end

endmodule

// File: tb/tb_bpm_test_link_rx.sv
// Randomized scoreboard bench for bpm_test_link_rx: packet-level reference model feeds
// expected queues, a negedge monitor pops and compares on every DUT strobe.
module tb_bpm_test_link_rx;

  localparam int          CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [15:0] MAGIC   = 16'hA5BE;
  localparam int          EW      = 2 + 5 + 96;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fa = 1'b0;
  logic [31:0]  tdata = '0;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;

  logic         packetStrobe;
  logic [4:0]   packetIndex;
  logic [95:0]  packetData;
  logic         statusStrobe;
  logic [1:0]   statusCode;
  logic [31:0]  cycleBitmap;
  logic [CNT_W-1:0] goodCount;
  logic [CNT_W-1:0] errorCount;
  logic [1:0]   fsm_state;

  int checks = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   bmp_q[$];
  logic [31:0]   model_work = '0;
  int            exp_good = 0;
  int            exp_err = 0;
  logic [4:0]    lg_idx = '0;
  logic [95:0]   lg_data = '0;
  logic          fa_edge = 1'b0;

  bpm_test_link_rx #(.COUNT_WIDTH(CNT_W)) dut (
    .auroraUserClk       (clk),
    .auroraResetN        (rst_n),
    .auroraFAstrobe      (fa),
    .AXI_STREAM_RX_tdata (tdata),
    .AXI_STREAM_RX_tvalid(tvalid),
    .AXI_STREAM_RX_tlast (tlast),
    .packetStrobe        (packetStrobe),
    .packetIndex         (packetIndex),
    .packetData          (packetData),
    .statusStrobe        (statusStrobe),
    .statusCode          (statusCode),
    .cycleBitmap         (cycleBitmap),
    .goodCount           (goodCount),
    .errorCount          (errorCount),
    .fsm_state_o         (fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic idle_cycle;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    @(posedge clk); #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic fa_cycle;
    fa = 1'b1;
    bmp_q.push_back(model_work);
    model_work = '0;
    idle_cycle();
    fa = 1'b0;
  endtask

  task automatic do_reset;
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    fa     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_packetStrobe", packetStrobe, 0);
    chk("rst_packetIndex", packetIndex, 0);
    chk("rst_packetData", packetData, 0);
    chk("rst_statusStrobe", statusStrobe, 0);
    chk("rst_statusCode", statusCode, 0);
    chk("rst_cycleBitmap", cycleBitmap, 0);
    chk("rst_goodCount", goodCount, 0);
    chk("rst_errorCount", errorCount, 0);
    chk("rst_fsm_state", fsm_state, 0);
    exp_q.delete();
    bmp_q.delete();
    model_work = '0;
    exp_good   = 0;
    exp_err    = 0;
    lg_idx     = '0;
    lg_data    = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Packet-level reference model: outcome depends only on magic and payload length.
  task automatic send_packet(input logic [31:0] hdr, input int n_data, input logic [191:0] pl,
                             input int gap_max, input logic fa_on_last);
    logic [1:0]  code;
    logic [4:0]  idx;
    logic [31:0] word;
    logic        last;
    idx = hdr[14:10];
    if (hdr[31:16] != MAGIC) code = 2'd1;
    else if (n_data < 3)     code = 2'd2;
    else if (n_data > 3)     code = 2'd3;
    else                     code = 2'd0;
    exp_q.push_back({code, idx, pl[95:0]});
    for (int b = 0; b <= n_data; b++) begin
      word = (b == 0) ? hdr : pl[(b-1)*32 +: 32];
      last = (b == n_data);
      repeat ($urandom_range(0, gap_max)) idle_cycle();
      if (last) begin
        if (code == 2'd0) model_work[idx] = 1'b1;
        if (fa_on_last) begin
          fa = 1'b1;
          bmp_q.push_back(model_work);
          model_work = '0;
        end
      end
      beat(word, last);
      fa = 1'b0;
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [15:0] magic, input logic [4:0] idx);
    logic [31:0] r;
    r = $urandom;
    return {magic, r[15], idx, r[9:0]};
  endfunction

  function automatic logic [191:0] rnd_payload();
    logic [191:0] p;
    for (int i = 0; i < 6; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // Scoreboard monitor
  always @(posedge clk) fa_edge <= fa & rst_n;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          g;
    if (rst_n) begin
      if (statusStrobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_status actual code=%0d expected no strobe", statusCode);
        end else begin
          e = exp_q.pop_front();
          g = (e[EW-1 -: 2] == 2'd0);
          chk("status_code", statusCode, e[EW-1 -: 2]);
          chk("packet_strobe", packetStrobe, g);
          if (g) begin
            lg_idx   = e[100:96];
            lg_data  = e[95:0];
            exp_good = (exp_good == CNT_MAX) ? CNT_MAX : exp_good + 1;
          end else begin
            exp_err = (exp_err == CNT_MAX) ? CNT_MAX : exp_err + 1;
          end
          chk("packet_index", packetIndex, lg_idx);
          chk("packet_data", packetData, lg_data);
          chk("good_count", goodCount, exp_good);
          chk("error_count", errorCount, exp_err);
        end
      end else begin
        chk("packet_strobe_idle", packetStrobe, 0);
      end
      if (fa_edge) begin
        if (bmp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fa_snapshot actual=%0h expected none", cycleBitmap);
        end else begin
          chk("cycle_bitmap", cycleBitmap, bmp_q.pop_front());
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [15:0] mg;
    int          nd;
    do_reset();

    // Directed good packet with gaps: index 3, payload 1,2,3
    send_packet(32'hA5BE_0C00, 3, {96'h0, 32'd3, 32'd2, 32'd1}, 3, 1'b0);
    // Bad magic then a good packet
    send_packet(32'h1234_0400, 3, rnd_payload(), 2, 1'b0);
    send_packet(mk_hdr(MAGIC, 5'd9), 3, rnd_payload(), 2, 1'b0);
    // Short (tlast on data word 1), long (tlast on 6th beat), header-only, then good
    send_packet(mk_hdr(MAGIC, 5'd2), 2, rnd_payload(), 1, 1'b0);
    send_packet(mk_hdr(MAGIC, 5'd4), 5, rnd_payload(), 1, 1'b0);
    send_packet(mk_hdr(MAGIC, 5'd6), 0, rnd_payload(), 1, 1'b0);
    send_packet(mk_hdr(16'h0000, 5'd6), 0, rnd_payload(), 1, 1'b0);
    send_packet(mk_hdr(MAGIC, 5'd8), 3, rnd_payload(), 1, 1'b0);

    // Bitmap: 0, 5, 31, then index 7 completing on the strobe edge
    fa_cycle();
    send_packet(mk_hdr(MAGIC, 5'd0), 3, rnd_payload(), 1, 1'b0);
    send_packet(mk_hdr(MAGIC, 5'd5), 3, rnd_payload(), 1, 1'b0);
    send_packet(mk_hdr(MAGIC, 5'd31), 3, rnd_payload(), 1, 1'b0);
    send_packet(mk_hdr(MAGIC, 5'd5), 3, rnd_payload(), 0, 1'b0);
    send_packet(mk_hdr(MAGIC, 5'd7), 3, rnd_payload(), 0, 1'b1);
    idle_cycle();
    fa_cycle();

    // Randomized traffic with interleaved FA strobes
    for (int i = 0; i < 60; i++) begin
      mg = ($urandom_range(0, 4) == 0) ? 16'($urandom) : MAGIC;
      nd = ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(0, 5);
      if ($urandom_range(0, 4) == 0) fa_cycle();
      send_packet(mk_hdr(mg, 5'($urandom_range(0, 31))), nd, rnd_payload(), 2,
                  ($urandom_range(0, 9) == 0));
    end
    fa_cycle();

    // Reset in the middle of a packet, then a clean packet
    beat(mk_hdr(MAGIC, 5'd12), 1'b0);
    beat(32'hDEAD_BEEF, 1'b0);
    do_reset();
    send_packet(mk_hdr(MAGIC, 5'd13), 3, rnd_payload(), 1, 1'b0);
    fa_cycle();

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 5; i++)
      send_packet(mk_hdr(MAGIC, 5'($urandom_range(0, 31))), 3, rnd_payload(), 0, 1'b0);
    repeat (3) idle_cycle();
    @(negedge clk);
    chk("good_count_saturated", goodCount, CNT_MAX);

    repeat (10) idle_cycle();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("bmp_q_drained", bmp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
